// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the CU/MAR/MDR handshake.
// A request is accepted on MOV, held for WAIT_CYCLES wait states, then one
// big-endian byte/halfword/word access is made on an internal byte array and
// completion is signalled on MOC (4-phase handshake).
// Optional feature macro: RAM_ALIGN_CHECK_EN (misaligned accesses flag ERR
// instead of having their low address bits forced to zero).
module ram_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        typeData,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              ERR
);

    localparam int unsigned Depth   = 2 ** ADDR_W;
    localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q;
    logic [1:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q, data_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;

    logic [7:0]        mem [Depth];

    // Request fields: live inputs in IDLE (zero-wait access), latched copy otherwise
    logic              req_rw;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [ADDR_W-1:0] eff_addr, a1, a2, a3;
    logic              mis;
    logic [31:0]       rdata;
    logic              access;
    logic              we;

    // Select request source and derive the effective (aligned) byte addresses
    always_comb begin
        req_rw    = (state_q == StIdle) ? RW       : rw_q;
        req_type  = (state_q == StIdle) ? typeData : type_q;
        req_addr  = (state_q == StIdle) ? Address  : addr_q;
        req_wdata = (state_q == StIdle) ? DataIn   : wdata_q;
        eff_addr  = req_addr;
        mis       = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
        mis = ((req_type == 2'b01) && req_addr[0]) ||
              (req_type[1] && (req_addr[1:0] != 2'b00));
`else
        if (req_type == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (req_type[1]) begin
            eff_addr[1:0] = 2'b00;
        end
`endif
        a1 = eff_addr + ADDR_W'(1);
        a2 = eff_addr + ADDR_W'(2);
        a3 = eff_addr + ADDR_W'(3);
    end

    // Big-endian read, zero-extended to 32 bits; 2'b11 behaves as word
    always_comb begin
        rdata = 32'h0;
        case (req_type)
            2'b00:   rdata = {24'h0, mem[eff_addr]};
            2'b01:   rdata = {16'h0, mem[eff_addr], mem[a1]};
            default: rdata = {mem[eff_addr], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    // Handshake FSM next-state, access strobe and registered output updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        moc_d   = moc_q;
        err_d   = err_q;
        mis_d   = mis_q;
        data_d  = data_q;
        access  = 1'b0;
        case (state_q)
            StIdle: begin
                moc_d = 1'b0;
                err_d = 1'b0;
                if (MOV) begin
                    cnt_d = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        access  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!MOV) begin
                    state_d = StIdle;
                end else if (cnt_q == LastCnt) begin
                    access  = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                // MOC/ERR follow one edge after the access edge
                if (MOV) begin
                    moc_d = 1'b1;
                    err_d = mis_q;
                end else begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (access) begin
            mis_d = mis;
            if (mis) begin
                data_d = 32'h0;
            end else if (req_rw) begin
                data_d = rdata;
            end
        end
    end

    // Gate with CLR so a held reset can never commit a zero-wait write
    assign we = access && !req_rw && !mis && CLR;

    // Control state, request latch and registered outputs
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            type_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
            if (state_q == StIdle && MOV) begin
                rw_q    <= RW;
                type_q  <= typeData;
                addr_q  <= Address;
                wdata_q <= DataIn;
            end
        end
    end

    // Byte array write port; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (we) begin
            case (req_type)
                2'b00: mem[eff_addr] <= req_wdata[7:0];
                2'b01: begin
                    mem[eff_addr] <= req_wdata[15:8];
                    mem[a1]       <= req_wdata[7:0];
                end
                default: begin
                    mem[eff_addr] <= req_wdata[31:24];
                    mem[a1]       <= req_wdata[23:16];
                    mem[a2]       <= req_wdata[15:8];
                    mem[a3]       <= req_wdata[7:0];
                end
            endcase
        end
    end

    assign DataOut = data_q;
    assign MOC     = moc_q;
    assign ERR     = err_q;

endmodule
